dlx_pipe_id: RTL and testbench

Instruction-decode stage of the DLX 5-stage pipeline, directly downstream of instruction fetch. It holds the 32×32 integer register file and decodes if_id_ir. It resolves branches and jumps in ID, returning id_npc/id_cond to fetch, and detects load-use and branch-operand hazards, driving the stall that freezes fetch. It launches operands, sign-extended immediate, IR and NPC into the ID/EX pipeline registers.

---
 rtl/dlx_pipe_id.sv | 149 ++++++++++++++
 tb/tb_dlx_pipe_id.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_pipe_id.sv
// dlx_pipe_id -- DLX instruction-decode stage.
// Holds the 32x32 register file, decodes if_id_ir, resolves branches/jumps
// in ID (id_cond/id_npc back to fetch), detects load-use and branch-operand
// hazards (stall to fetch) and launches operands into the ID/EX registers.
// Ports:
//   clk, rst                 clock, async active-high reset
//   dc_wait                  data-cache miss; freezes ID/EX
//   if_id_ir, if_id_npc      instruction in ID and its PC+4
//   wb_we, wb_rd, wb_data    register-file write port
//   ex_mem_we, ex_mem_rd     destination of the instruction in MEM
//   stall, id_cond, id_npc   combinational feedback to fetch
//   id_ex_*                  ID/EX pipeline registers
module dlx_pipe_id (
  input  logic        clk,
  input  logic        rst,
  input  logic        dc_wait,
  input  logic [31:0] if_id_ir,
  input  logic [31:0] if_id_npc,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_we,
  input  logic [4:0]  ex_mem_rd,
  output logic        stall,
  output logic        id_cond,
  output logic [31:0] id_npc,
  output logic [31:0] id_ex_a,
  output logic [31:0] id_ex_b,
  output logic [31:0] id_ex_imm,
  output logic [31:0] id_ex_ir,
  output logic [31:0] id_ex_npc
);

  localparam logic [31:0] NOP_IR = 32'h5400_0000;

  function automatic logic is_load(input logic [5:0] opc);
    return opc inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  // Destination register of an instruction; 0 means "writes nothing".
  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    logic [5:0] opc;
    logic [4:0] d;
    opc = ir[31:26];
    d   = 5'd0;
    if (opc == 6'h00)
      d = ir[15:11];
    else if (opc == 6'h03 || opc == 6'h13)
      d = 5'd31;
    else if (is_load(opc) || (opc inside {[6'h08:6'h0F], [6'h18:6'h1D]}))
      d = ir[20:16];
    return d;
  endfunction

  logic [31:0] regs [32];

  logic [5:0]  op;
  logic [4:0]  rs1, rs2;
  logic [31:0] rd_a, rd_b, imm_sext, off_sext;
  logic        use_rs1, use_rs2;
  logic [4:0]  ex_rd;
  logic        load_use, br_hazard;
  logic        cond_raw;

  assign op       = if_id_ir[31:26];
  assign rs1      = if_id_ir[25:21];
  assign rs2      = if_id_ir[20:16];
  assign imm_sext = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
  assign off_sext = {{6{if_id_ir[25]}}, if_id_ir[25:0]};

  // Reads see a same-cycle writeback so WB->ID needs no extra bubble.
  assign rd_a = (rs1 == 5'd0) ? 32'd0 :
                (wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rd_b = (rs2 == 5'd0) ? 32'd0 :
                (wb_we && wb_rd == rs2) ? wb_data : regs[rs2];

  // Stores read the data register through the rs2 field.
  assign use_rs1 = !(op inside {6'h02, 6'h03, 6'h15});
  assign use_rs2 = (op == 6'h00) || (op inside {6'h28, 6'h29, 6'h2B});

  assign ex_rd    = dest_of(id_ex_ir);
  assign load_use = is_load(id_ex_ir[31:26]) && (ex_rd != 5'd0) &&
                    ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));

  // Branches resolve in ID, so their operand cannot be forwarded from EX/MEM.
  assign br_hazard = (op inside {6'h04, 6'h05, 6'h12, 6'h13}) && (rs1 != 5'd0) &&
                     ((rs1 == ex_rd) || (ex_mem_we && ex_mem_rd == rs1));

  assign stall = (load_use || br_hazard) && !dc_wait;

  always_comb begin
    cond_raw = 1'b0;
    id_npc   = if_id_npc;
    case (op)
      6'h04: begin
        cond_raw = (rd_a == 32'd0);
        if (cond_raw) id_npc = if_id_npc + imm_sext;
      end
      6'h05: begin
        cond_raw = (rd_a != 32'd0);
        if (cond_raw) id_npc = if_id_npc + imm_sext;
      end
      6'h02, 6'h03: begin
        cond_raw = 1'b1;
        id_npc   = if_id_npc + off_sext;
      end
      6'h12, 6'h13: begin
        cond_raw = 1'b1;
        id_npc   = rd_a;
      end
      default: ;
    endcase
  end

  assign id_cond = cond_raw && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_we && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_ir  <= NOP_IR;
      id_ex_npc <= 32'd0;
      id_ex_a   <= 32'd0;
      id_ex_b   <= 32'd0;
      id_ex_imm <= 32'd0;
    end else if (!dc_wait) begin
      if (stall) begin
        id_ex_ir  <= NOP_IR;
        id_ex_npc <= 32'd0;
        id_ex_a   <= 32'd0;
        id_ex_b   <= 32'd0;
        id_ex_imm <= 32'd0;
      end else begin
        id_ex_ir  <= if_id_ir;
        id_ex_npc <= if_id_npc;
        id_ex_a   <= rd_a;
        id_ex_b   <= rd_b;
        id_ex_imm <= imm_sext;
      end
    end
  end

endmodule

// File: tb/tb_dlx_pipe_id.sv
// tb_dlx_pipe_id -- directed scenarios plus a randomized run against a
// behavioural model of the decode stage.
module tb_dlx_pipe_id;

  localparam logic [31:0] NOP_IR = 32'h5400_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dc_wait = 1'b0;
  logic [31:0] if_id_ir = NOP_IR;
  logic [31:0] if_id_npc = 32'd0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        ex_mem_we = 1'b0;
  logic [4:0]  ex_mem_rd = 5'd0;
  logic        stall, id_cond;
  logic [31:0] id_npc, id_ex_a, id_ex_b, id_ex_imm, id_ex_ir, id_ex_npc;

  int n_vec = 0;
  int n_err = 0;

  dlx_pipe_id dut (
    .clk(clk), .rst(rst), .dc_wait(dc_wait),
    .if_id_ir(if_id_ir), .if_id_npc(if_id_npc),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_mem_we(ex_mem_we), .ex_mem_rd(ex_mem_rd),
    .stall(stall), .id_cond(id_cond), .id_npc(id_npc),
    .id_ex_a(id_ex_a), .id_ex_b(id_ex_b), .id_ex_imm(id_ex_imm),
    .id_ex_ir(id_ex_ir), .id_ex_npc(id_ex_npc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    return {6'h00, a, b, d, 11'h020};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] a, input logic [4:0] d, input logic [15:0] im);
    return {o, a, d, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] npc);
    if_id_ir  = ir;
    if_id_npc = npc;
    wb_we     = 1'b0;
    dc_wait   = 1'b0;
    ex_mem_we = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    drive(NOP_IR, 32'd0);
    wb_we = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [32];
  logic [31:0] m_ir, m_a, m_b, m_imm, m_npc;

  function automatic bit m_is_load(input logic [31:0] ir);
    return ir[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] ir);
    logic [5:0] o;
    o = ir[31:26];
    if (o == 6'h00) return ir[15:11];
    if (o == 6'h03 || o == 6'h13) return 5'd31;
    if (m_is_load(ir) || (o >= 6'h08 && o <= 6'h0F) || (o >= 6'h18 && o <= 6'h1D)) return ir[20:16];
    return 5'd0;
  endfunction

  function automatic bit m_reads(input logic [31:0] ir, input logic [4:0] r);
    logic [5:0] o;
    bit r1, r2;
    o = ir[31:26];
    if (r == 5'd0) return 1'b0;
    r1 = !(o == 6'h02 || o == 6'h03 || o == 6'h15);
    r2 = (o == 6'h00) || o == 6'h28 || o == 6'h29 || o == 6'h2B;
    return (r1 && ir[25:21] == r) || (r2 && ir[20:16] == r);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; drive(NOP_IR, 0);
    repeat (2) tick();
    rst = 1'b0;
    wb_write(5'd1, 32'hDEAD_0001);
    wb_write(5'd31, 32'hDEAD_001F);
    drive(itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h10);
    tick();
    drive(rtype(5'd2, 5'd1, 5'd4), 32'h14);
    #2;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL pre_reset_stall got %b exp 1", stall); end
    rst = 1'b1;
    #1;
    n_vec++; if (id_ex_ir !== NOP_IR) begin n_err++; $display("FAIL reset_ir got %h exp %h", id_ex_ir, NOP_IR); end
    n_vec++; if (id_ex_a !== 32'd0) begin n_err++; $display("FAIL reset_a got %h exp 0", id_ex_a); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_vec++; if (id_cond !== 1'b0) begin n_err++; $display("FAIL reset_cond got %b exp 0", id_cond); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive(rtype(5'(i), 5'(i), 5'd0), 32'h0);
      tick();
      n_vec++;
      if (id_ex_a !== 32'd0 || id_ex_b !== 32'd0) begin
        n_err++; $display("FAIL reset_rf r%0d got %h/%h exp 0", i, id_ex_a, id_ex_b);
      end
    end
  endtask

  task automatic test_bypass();
    drive(rtype(5'd5, 5'd5, 5'd3), 32'h40);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
    tick();
    n_vec++; if (id_ex_a !== 32'h1234_5678) begin n_err++; $display("FAIL bypass_a got %h exp 12345678", id_ex_a); end
    n_vec++; if (id_ex_b !== 32'h1234_5678) begin n_err++; $display("FAIL bypass_b got %h exp 12345678", id_ex_b); end
    n_vec++; if (id_ex_npc !== 32'h40) begin n_err++; $display("FAIL bypass_npc got %h exp 40", id_ex_npc); end
    drive(rtype(5'd0, 5'd0, 5'd3), 32'h44);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    n_vec++; if (id_ex_a !== 32'd0) begin n_err++; $display("FAIL r0_bypass got %h exp 0", id_ex_a); end
    drive(rtype(5'd0, 5'd0, 5'd3), 32'h48);
    tick();
    n_vec++; if (id_ex_a !== 32'd0) begin n_err++; $display("FAIL r0_write got %h exp 0", id_ex_a); end
  endtask

  task automatic test_load_use();
    wb_write(5'd2, 32'hA5A5_A5A5);
    wb_write(5'd1, 32'h0000_0011);
    drive(itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h50);
    tick();
    drive(rtype(5'd2, 5'd1, 5'd4), 32'h54);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", stall); end
    tick();
    n_vec++; if (id_ex_ir !== NOP_IR) begin n_err++; $display("FAIL lu_bubble got %h exp %h", id_ex_ir, NOP_IR); end
    n_vec++; if (id_ex_a !== 32'd0) begin n_err++; $display("FAIL lu_bubble_a got %h exp 0", id_ex_a); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_release got %b exp 0", stall); end
    tick();
    n_vec++; if (id_ex_ir !== rtype(5'd2, 5'd1, 5'd4)) begin n_err++; $display("FAIL lu_issue_ir got %h", id_ex_ir); end
    n_vec++; if (id_ex_a !== 32'hA5A5_A5A5 || id_ex_b !== 32'h11) begin n_err++; $display("FAIL lu_issue_ops got %h/%h exp a5a5a5a5/11", id_ex_a, id_ex_b); end
  endtask

  task automatic test_branch();
    wb_write(5'd7, 32'd0);
    drive(itype(6'h04, 5'd7, 5'd0, 16'hFFF8), 32'h100);
    #1;
    n_vec++; if (id_cond !== 1'b1 || id_npc !== 32'hF8) begin n_err++; $display("FAIL beqz_taken got %b/%h exp 1/f8", id_cond, id_npc); end
    wb_write(5'd7, 32'd3);
    drive(itype(6'h04, 5'd7, 5'd0, 16'hFFF8), 32'h100);
    #1;
    n_vec++; if (id_cond !== 1'b0 || id_npc !== 32'h100) begin n_err++; $display("FAIL beqz_not got %b/%h exp 0/100", id_cond, id_npc); end
    drive(itype(6'h05, 5'd7, 5'd0, 16'h0010), 32'h100);
    #1;
    n_vec++; if (id_cond !== 1'b1 || id_npc !== 32'h110) begin n_err++; $display("FAIL bnez_taken got %b/%h exp 1/110", id_cond, id_npc); end
    drive({6'h02, 26'h3FF_FFF0}, 32'h200);
    #1;
    n_vec++; if (id_cond !== 1'b1 || id_npc !== 32'h1F0) begin n_err++; $display("FAIL j_back got %b/%h exp 1/1f0", id_cond, id_npc); end
    drive(itype(6'h12, 5'd7, 5'd0, 16'h0), 32'h200);
    #1;
    n_vec++; if (id_cond !== 1'b1 || id_npc !== 32'h3) begin n_err++; $display("FAIL jr got %b/%h exp 1/3", id_cond, id_npc); end
  endtask

  task automatic test_branch_hazard();
    drive(itype(6'h08, 5'd0, 5'd7, 16'd5), 32'h2FC);
    tick();
    drive(itype(6'h05, 5'd7, 5'd0, 16'h0020), 32'h300);
    #1;
    n_vec++; if (stall !== 1'b1 || id_cond !== 1'b0) begin n_err++; $display("FAIL bh_ex got %b/%b exp 1/0", stall, id_cond); end
    tick();
    ex_mem_we = 1'b1; ex_mem_rd = 5'd7;
    #1;
    n_vec++; if (stall !== 1'b1 || id_cond !== 1'b0) begin n_err++; $display("FAIL bh_mem got %b/%b exp 1/0", stall, id_cond); end
    n_vec++; if (id_ex_ir !== NOP_IR) begin n_err++; $display("FAIL bh_bubble got %h exp %h", id_ex_ir, NOP_IR); end
    tick();
    ex_mem_we = 1'b0; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'd5;
    #1;
    n_vec++; if (stall !== 1'b0 || id_cond !== 1'b1 || id_npc !== 32'h320) begin n_err++; $display("FAIL bh_resolve got %b/%b/%h exp 0/1/320", stall, id_cond, id_npc); end
    tick();
    wb_we = 1'b0;
    n_vec++; if (id_ex_ir !== itype(6'h05, 5'd7, 5'd0, 16'h0020) || id_ex_a !== 32'd5) begin n_err++; $display("FAIL bh_issue got %h/%h", id_ex_ir, id_ex_a); end
  endtask

  task automatic test_dc_wait();
    drive(itype(6'h08, 5'd0, 5'd9, 16'd7), 32'h400);
    tick();
    drive(rtype(5'd5, 5'd5, 5'd3), 32'h404);
    dc_wait = 1'b1; wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL dcw_stall got %b exp 0", stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      wb_we = 1'b0;
      n_vec++;
      if (id_ex_ir !== itype(6'h08, 5'd0, 5'd9, 16'd7) || id_ex_imm !== 32'd7 || id_ex_npc !== 32'h400) begin
        n_err++; $display("FAIL dcw_hold%0d got %h/%h/%h", i, id_ex_ir, id_ex_imm, id_ex_npc);
      end
    end
    dc_wait = 1'b0;
    tick();
    n_vec++; if (id_ex_ir !== rtype(5'd5, 5'd5, 5'd3) || id_ex_a !== 32'h1234_5678 || id_ex_npc !== 32'h404) begin n_err++; $display("FAIL dcw_resume got %h/%h/%h", id_ex_ir, id_ex_a, id_ex_npc); end
    drive(rtype(5'd6, 5'd0, 5'd0), 32'h408);
    tick();
    n_vec++; if (id_ex_ir !== rtype(5'd6, 5'd0, 5'd0) || id_ex_a !== 32'h66) begin n_err++; $display("FAIL dcw_once got %h/%h exp wb-during-wait 66", id_ex_ir, id_ex_a); end
    drive(itype(6'h23, 5'd0, 5'd2, 16'h0), 32'h40C);
    tick();
    drive(rtype(5'd2, 5'd0, 5'd4), 32'h410);
    dc_wait = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL dcw_masks_stall got %b exp 0", stall); end
    tick();
    dc_wait = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b1 || id_ex_ir !== itype(6'h23, 5'd0, 5'd2, 16'h0)) begin n_err++; $display("FAIL dcw_lu got %b/%h", stall, id_ex_ir); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops [13] = '{6'h00, 6'h08, 6'h0A, 6'h23, 6'h20, 6'h2B, 6'h04,
                              6'h05, 6'h02, 6'h03, 6'h12, 6'h13, 6'h15};
    logic [31:0] ea, eb, tgt;
    logic [5:0]  o;
    logic [4:0]  d;
    logic [15:0] lo;
    bit c, lu, bh, es, hold;
    rst = 1'b1; drive(NOP_IR, 0); #2; rst = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_ir = NOP_IR; m_a = 0; m_b = 0; m_imm = 0; m_npc = 0;
    tick();
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        lo = 16'($urandom_range(0, 65535));
        if_id_ir  = {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), lo};
        if_id_npc = $urandom & 32'hFFFF_FFFC;
      end
      dc_wait   = ($urandom_range(0, 7) == 0);
      wb_we     = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 3));
      wb_data   = $urandom;
      ex_mem_we = 1'($urandom_range(0, 1));
      ex_mem_rd = 5'($urandom_range(0, 3));
      #1;
      o  = if_id_ir[31:26];
      ea = m_read(if_id_ir[25:21]);
      eb = m_read(if_id_ir[20:16]);
      d  = m_dest(m_ir);
      lu = m_is_load(m_ir) && d != 0 && m_reads(if_id_ir, d);
      bh = (o == 6'h04 || o == 6'h05 || o == 6'h12 || o == 6'h13) && if_id_ir[25:21] != 0 &&
           (if_id_ir[25:21] == d || (ex_mem_we && ex_mem_rd == if_id_ir[25:21]));
      es = (lu || bh) && !dc_wait;
      c = 1'b0; tgt = if_id_npc;
      if (o == 6'h04 && ea == 0) begin c = 1; tgt = if_id_npc + 32'($signed(if_id_ir[15:0])); end
      if (o == 6'h05 && ea != 0) begin c = 1; tgt = if_id_npc + 32'($signed(if_id_ir[15:0])); end
      if (o == 6'h02 || o == 6'h03) begin c = 1; tgt = if_id_npc + 32'($signed(if_id_ir[25:0])); end
      if (o == 6'h12 || o == 6'h13) begin c = 1; tgt = ea; end
      n_vec++; if (stall !== es) begin n_err++; $display("FAIL rnd_stall n=%0d ir=%h got %b exp %b", n, if_id_ir, stall, es); end
      n_vec++; if (id_cond !== (c && !es)) begin n_err++; $display("FAIL rnd_cond n=%0d ir=%h got %b exp %b", n, if_id_ir, id_cond, c && !es); end
      if (!es) begin
        n_vec++; if (id_npc !== tgt) begin n_err++; $display("FAIL rnd_npc n=%0d ir=%h got %h exp %h", n, if_id_ir, id_npc, tgt); end
      end
      hold = es || dc_wait;
      tick();
      if (!dc_wait) begin
        if (es) begin
          m_ir = NOP_IR; m_a = 0; m_b = 0; m_imm = 0; m_npc = 0;
        end else begin
          m_ir = if_id_ir; m_npc = if_id_npc; m_a = ea; m_b = eb; m_imm = 32'($signed(if_id_ir[15:0]));
        end
      end
      if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
      n_vec++;
      if (id_ex_ir !== m_ir || id_ex_a !== m_a || id_ex_b !== m_b || id_ex_imm !== m_imm || id_ex_npc !== m_npc) begin
        n_err++;
        $display("FAIL rnd_idex n=%0d got ir=%h a=%h b=%h imm=%h npc=%h exp ir=%h a=%h b=%h imm=%h npc=%h",
                 n, id_ex_ir, id_ex_a, id_ex_b, id_ex_imm, id_ex_npc, m_ir, m_a, m_b, m_imm, m_npc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_branch();
    test_branch_hazard();
    test_dc_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
